mc_port_responder: RTL and testbench

Single-port memory-controller responder: the MC-side end of the personality request/response interface. It accepts load/store requests on one MC port, services them from an internal word-addressed scratch memory, returns in-order read responses with backpressure, and completes write flushes. It is the reusable MC endpoint for simulation benches and for on-FPGA loopback of personality logic without host memory.

---
 rtl/mc_port_responder_pkg.sv | 65 ++++++
 rtl/mc_rsp_fifo.sv | 46 ++++
 rtl/mc_port_responder.sv | 182 ++++++++++++++++++
 tb/tb_mc_port_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_port_responder_pkg.sv
// Shared types and constants for the MC port responder: request size codes,
// MC bus widths, the response record and the flush FSM states.
package mc_port_responder_pkg;

  localparam int unsigned MC_VADR_W  = 48;
  localparam int unsigned MC_DATA_W  = 64;
  localparam int unsigned MC_RDCTL_W = 32;
  localparam int unsigned RSP_W      = MC_DATA_W + MC_RDCTL_W;

  typedef enum logic [1:0] {
    SZ_1B = 2'd0,
    SZ_2B = 2'd1,
    SZ_4B = 2'd2,
    SZ_8B = 2'd3
  } req_size_t;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_DRAIN = 2'd1,
    FL_DONE  = 2'd2
  } flush_state_t;

  typedef struct packed {
    logic [MC_DATA_W-1:0]  data;
    logic [MC_RDCTL_W-1:0] rdctl;
  } rsp_t;

  // Byte lanes covered by an access of the given size, starting at lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    logic [7:0] m;
    m = 8'h01;
    case (req_size_t'(size))
      SZ_1B:   m = 8'h01;
      SZ_2B:   m = 8'h03;
      SZ_4B:   m = 8'h0F;
      SZ_8B:   m = 8'hFF;
      default: m = 8'h01;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    m = 3'd0;
    case (req_size_t'(size))
      SZ_1B:   m = 3'd0;
      SZ_2B:   m = 3'd1;
      SZ_4B:   m = 3'd3;
      SZ_8B:   m = 3'd7;
      default: m = 3'd0;
    endcase
    return m;
  endfunction

  function automatic logic [MC_DATA_W-1:0] lanes_to_bits(input logic [7:0] lanes);
    logic [MC_DATA_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      m[b*8 +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mc_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; only the pointers and the
// count are reset, storage is left as-is.
module mc_rsp_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mc_port_responder.sv
// MC-side responder: services loads/stores from a local word memory, returns
// in-order read responses under backpressure and completes write flushes.
module mc_port_responder
  import mc_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RSP_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mc_req_ld,
  input  logic                  mc_req_st,
  input  logic [1:0]            mc_req_size,
  input  logic [MC_VADR_W-1:0]  mc_req_vadr,
  input  logic [MC_DATA_W-1:0]  mc_req_wrd_rdctl,
  output logic                  mc_rd_rq_stall,
  output logic                  mc_wr_rq_stall,
  input  logic                  mc_rsp_stall,
  output logic                  mc_rsp_push,
  output logic [MC_DATA_W-1:0]  mc_rsp_data,
  output logic [MC_RDCTL_W-1:0] mc_rsp_rdctl,
  input  logic                  mc_req_flush,
  output logic                  mc_rsp_flush_cmplt,
  output logic                  protocol_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [MC_DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0]    word_idx;
  logic [2:0]           offset;
  logic                 aligned;
  logic [7:0]           byte_en;
  logic [MC_DATA_W-1:0] st_data;
  logic [MC_DATA_W-1:0] ld_word;
  logic [MC_DATA_W-1:0] ld_data;
  logic                 ld_ok;
  logic                 st_ok;
  logic                 req_err;
  logic                 unused_vadr;

  logic [RSP_LAT-1:0]   pipe_vld;
  rsp_t                 pipe_q [RSP_LAT];
  rsp_t                 tail;
  logic                 tail_vld;

  logic                 fifo_wr;
  logic                 fifo_pop;
  logic                 bypass;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  rsp_t                 fifo_head;

  int unsigned          occupancy;
  flush_state_t         fl_state;

  assign word_idx    = mc_req_vadr[ADDR_W+2:3];
  assign offset      = mc_req_vadr[2:0];
  assign aligned     = (offset & align_mask(mc_req_size)) == 3'd0;
  assign byte_en     = lane_mask(mc_req_size) << offset;
  assign st_data     = mc_req_wrd_rdctl << {offset, 3'b000};
  assign ld_word     = mem[word_idx];
  assign ld_data     = (ld_word >> {offset, 3'b000}) & lanes_to_bits(lane_mask(mc_req_size));
  assign unused_vadr = ^mc_req_vadr[MC_VADR_W-1:ADDR_W+3];

  always_comb begin
    occupancy = 32'(fifo_count);
    for (int unsigned i = 0; i < RSP_LAT; i++) begin
      occupancy = occupancy + 32'(pipe_vld[i]);
    end
  end

  assign mc_wr_rq_stall = (fl_state != FL_IDLE);
  assign mc_rd_rq_stall = (occupancy >= FIFO_DEPTH) || mc_wr_rq_stall;

  assign ld_ok   = mc_req_ld & ~mc_req_st & ~mc_rd_rq_stall & aligned;
  assign st_ok   = mc_req_st & ~mc_req_ld & ~mc_wr_rq_stall & aligned;
  assign req_err = (mc_req_ld & mc_req_st)
                 | (mc_req_ld & mc_rd_rq_stall)
                 | (mc_req_st & mc_wr_rq_stall)
                 | ((mc_req_ld | mc_req_st) & ~aligned)
                 | (mc_req_flush & (fl_state != FL_IDLE));

  always_ff @(posedge clock) begin
    if (st_ok) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= st_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= ld_ok;
      for (int unsigned i = 1; i < RSP_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    pipe_q[0] <= '{data: ld_data, rdctl: mc_req_wrd_rdctl[MC_RDCTL_W-1:0]};
    for (int unsigned i = 1; i < RSP_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail     = pipe_q[RSP_LAT-1];
  assign tail_vld = pipe_vld[RSP_LAT-1];

  // With the FIFO empty the last pipeline stage feeds the output register
  // directly, so an unstalled load sees no extra FIFO cycle.
  assign fifo_pop = ~mc_rsp_stall & ~fifo_empty;
  assign bypass   = ~mc_rsp_stall & fifo_empty & tail_vld;
  assign fifo_wr  = tail_vld & ~bypass;

  mc_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (tail),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mc_rsp_push  <= 1'b0;
      mc_rsp_data  <= '0;
      mc_rsp_rdctl <= '0;
    end else begin
      mc_rsp_push <= fifo_pop | bypass;
      if (fifo_pop) begin
        mc_rsp_data  <= fifo_head.data;
        mc_rsp_rdctl <= fifo_head.rdctl;
      end else if (bypass) begin
        mc_rsp_data  <= tail.data;
        mc_rsp_rdctl <= tail.rdctl;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fl_state           <= FL_IDLE;
      mc_rsp_flush_cmplt <= 1'b0;
      protocol_err       <= 1'b0;
    end else begin
      if (req_err) protocol_err <= 1'b1;
      unique case (fl_state)
        FL_IDLE: begin
          mc_rsp_flush_cmplt <= 1'b0;
          if (mc_req_flush) fl_state <= FL_DRAIN;
        end
        FL_DRAIN: begin
          if (occupancy == 0 && !(fifo_pop | bypass)) begin
            fl_state           <= FL_DONE;
            mc_rsp_flush_cmplt <= 1'b1;
          end
        end
        FL_DONE: begin
          fl_state           <= FL_IDLE;
          mc_rsp_flush_cmplt <= 1'b0;
        end
        default: begin
          fl_state           <= FL_IDLE;
          mc_rsp_flush_cmplt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_port_responder.sv
// Self-checking bench for mc_port_responder against a byte-array memory model
// and an in-order expected-response queue.
module tb_mc_port_responder;

  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mc_req_ld = 1'b0;
  logic        mc_req_st = 1'b0;
  logic [1:0]  mc_req_size = 2'd0;
  logic [47:0] mc_req_vadr = '0;
  logic [63:0] mc_req_wrd_rdctl = '0;
  logic        mc_rd_rq_stall;
  logic        mc_wr_rq_stall;
  logic        mc_rsp_stall = 1'b0;
  logic        mc_rsp_push;
  logic [63:0] mc_rsp_data;
  logic [31:0] mc_rsp_rdctl;
  logic        mc_req_flush = 1'b0;
  logic        mc_rsp_flush_cmplt;
  logic        protocol_err;

  always #5 clock = ~clock;

  mc_port_responder #(
    .ADDR_W     (10),
    .RSP_LAT    (LAT),
    .FIFO_DEPTH (8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .mc_req_ld          (mc_req_ld),
    .mc_req_st          (mc_req_st),
    .mc_req_size        (mc_req_size),
    .mc_req_vadr        (mc_req_vadr),
    .mc_req_wrd_rdctl   (mc_req_wrd_rdctl),
    .mc_rd_rq_stall     (mc_rd_rq_stall),
    .mc_wr_rq_stall     (mc_wr_rq_stall),
    .mc_rsp_stall       (mc_rsp_stall),
    .mc_rsp_push        (mc_rsp_push),
    .mc_rsp_data        (mc_rsp_data),
    .mc_rsp_rdctl       (mc_rsp_rdctl),
    .mc_req_flush       (mc_req_flush),
    .mc_rsp_flush_cmplt (mc_rsp_flush_cmplt),
    .protocol_err       (protocol_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [31:0] rdctl;
    int unsigned cyc;
  } rsp_rec_t;

  rsp_rec_t    obs_q[$];
  rsp_rec_t    exp_q[$];
  logic [7:0]  byte_mem [8192];
  int unsigned cyc = 0;
  int unsigned cmplt_cnt = 0;
  int unsigned cmplt_cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset === 1'b1 && mc_rsp_push === 1'b1)
      obs_q.push_back('{data: mc_rsp_data, rdctl: mc_rsp_rdctl, cyc: cyc});
    if (reset === 1'b1 && mc_rsp_flush_cmplt === 1'b1) begin
      cmplt_cnt <= cmplt_cnt + 1;
      cmplt_cyc <= cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

  function automatic bit is_aligned(input logic [47:0] a, input logic [1:0] sz);
    return (32'(a[2:0]) % nbytes(sz)) == 0;
  endfunction

  function automatic void model_store(input logic [47:0] a, input logic [1:0] sz, input logic [63:0] d);
    for (int unsigned b = 0; b < nbytes(sz); b++)
      byte_mem[(32'(a[12:0]) + b) % 8192] = d[8*b +: 8];
  endfunction

  function automatic logic [63:0] model_load(input logic [47:0] a, input logic [1:0] sz);
    logic [63:0] r;
    r = '0;
    for (int unsigned b = 0; b < nbytes(sz); b++)
      r[8*b +: 8] = byte_mem[(32'(a[12:0]) + b) % 8192];
    return r;
  endfunction

  function automatic logic [47:0] rand_addr(input logic [1:0] sz);
    logic [63:0] h;
    logic [2:0]  off;
    h   = {$urandom, $urandom};
    off = 3'($urandom_range(0, 7)) & ~3'(nbytes(sz) - 1);
    return (h[47:0] & 48'hFFFF_FFFF_E000) | (48'($urandom_range(0, 31)) << 3) | 48'(off);
  endfunction

  // ---------------- drivers (called at #1 after a rising edge) ----------------
  task automatic idle_cycle();
    @(posedge clock); #1;
  endtask

  task automatic issue_st(input logic [47:0] a, input logic [1:0] sz, input logic [63:0] d);
    mc_req_st = 1'b1; mc_req_vadr = a; mc_req_size = sz; mc_req_wrd_rdctl = d;
    @(posedge clock); #1;
    mc_req_st = 1'b0;
    if (is_aligned(a, sz)) model_store(a, sz, d);
  endtask

  task automatic issue_ld(input logic [47:0] a, input logic [1:0] sz, input logic [31:0] tag);
    if (is_aligned(a, sz))
      exp_q.push_back('{data: model_load(a, sz), rdctl: tag, cyc: cyc + LAT + 1});
    mc_req_ld = 1'b1; mc_req_vadr = a; mc_req_size = sz; mc_req_wrd_rdctl = {32'h0, tag};
    @(posedge clock); #1;
    mc_req_ld = 1'b0;
  endtask

  task automatic wait_obs(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && obs_q.size() < int'(n); i++) idle_cycle();
  endtask

  task automatic do_reset();
    mc_req_ld = 1'b0; mc_req_st = 1'b0; mc_req_flush = 1'b0; mc_rsp_stall = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    obs_q.delete(); exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (mc_rsp_push !== 1'b0) begin n_fail++; $display("FAIL reset_push got %b want 0", mc_rsp_push); end
    n_checks++; if (mc_rsp_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", mc_rsp_data); end
    n_checks++; if (mc_rsp_rdctl !== 32'h0) begin n_fail++; $display("FAIL reset_rdctl got %h want 0", mc_rsp_rdctl); end
    n_checks++; if (mc_rsp_flush_cmplt !== 1'b0) begin n_fail++; $display("FAIL reset_cmplt got %b want 0", mc_rsp_flush_cmplt); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", protocol_err); end
    n_checks++; if (mc_rd_rq_stall !== 1'b0) begin n_fail++; $display("FAIL reset_rd_stall got %b want 0", mc_rd_rq_stall); end
    n_checks++; if (mc_wr_rq_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stall got %b want 0", mc_wr_rq_stall); end
    reset = 1'b1;
    repeat (2) idle_cycle();
    n_checks++; if (mc_rsp_push !== 1'b0) begin n_fail++; $display("FAIL post_reset_push got %b want 0", mc_rsp_push); end
  endtask

  task automatic test_store_load();
    rsp_rec_t o, e;
    obs_q.delete(); exp_q.delete();
    issue_st(48'h40, 2'd3, 64'h1122334455667788);
    issue_ld(48'h40, 2'd3, 32'h5);
    wait_obs(1, 20);
    repeat (2) idle_cycle();
    n_checks++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL st_ld_count got %0d want 1", obs_q.size()); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== 64'h1122334455667788) begin n_fail++; $display("FAIL st_ld_data got %h want 1122334455667788", o.data); end
      n_checks++; if (o.rdctl !== 32'h5) begin n_fail++; $display("FAIL st_ld_rdctl got %h want 5", o.rdctl); end
      n_checks++; if (o.cyc !== e.cyc) begin n_fail++; $display("FAIL st_ld_latency got cycle %0d want %0d", o.cyc, e.cyc); end
    end
  endtask

  task automatic test_byte_lanes();
    rsp_rec_t o;
    obs_q.delete(); exp_q.delete();
    issue_st(48'h43, 2'd0, 64'hAB);
    issue_ld(48'h42, 2'd1, 32'h77);
    wait_obs(1, 20);
    n_checks++;
    if (obs_q.size() < 1) begin n_fail++; $display("FAIL lanes_count got %0d want 1", obs_q.size()); end
    else begin
      o = obs_q.pop_front();
      n_checks++; if (o.data !== 64'h000000000000AB66) begin n_fail++; $display("FAIL lanes_data got %h want 000000000000ab66", o.data); end
    end
  endtask

  task automatic test_backpressure();
    int unsigned accepted;
    rsp_rec_t o, e;
    obs_q.delete(); exp_q.delete();
    accepted = 0;
    mc_rsp_stall = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      if (!mc_rd_rq_stall) begin
        issue_ld(48'h40 | 48'(i % 8), 2'd0, 32'h100 + i);
        accepted++;
      end else idle_cycle();
    end
    n_checks++; if (accepted !== 8) begin n_fail++; $display("FAIL bp_accepted got %0d want 8", accepted); end
    n_checks++; if (mc_rd_rq_stall !== 1'b1) begin n_fail++; $display("FAIL bp_rd_stall got %b want 1", mc_rd_rq_stall); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_held got %0d pushes want 0", obs_q.size()); end
    mc_rsp_stall = 1'b0;
    wait_obs(8, 30);
    repeat (3) idle_cycle();
    n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.rdctl !== e.rdctl) begin
        n_fail++; $display("FAIL bp_order got %h/%h want %h/%h", o.data, o.rdctl, e.data, e.rdctl);
      end
    end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL bp_err got %b want 0", protocol_err); end
  endtask

  task automatic test_flush();
    int unsigned c0, t_fl;
    obs_q.delete(); exp_q.delete();
    issue_ld(48'h40, 2'd3, 32'hA1);
    issue_ld(48'h42, 2'd1, 32'hA2);
    c0 = cmplt_cnt;
    mc_req_flush = 1'b1;
    @(posedge clock); #1;
    mc_req_flush = 1'b0;
    n_checks++; if (mc_rd_rq_stall !== 1'b1) begin n_fail++; $display("FAIL flush_rd_stall got %b want 1", mc_rd_rq_stall); end
    n_checks++; if (mc_wr_rq_stall !== 1'b1) begin n_fail++; $display("FAIL flush_wr_stall got %b want 1", mc_wr_rq_stall); end
    for (int unsigned i = 0; i < 20 && cmplt_cnt == c0; i++) @(posedge clock);
    #1;
    n_checks++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL flush_pushes got %0d want 2", obs_q.size()); end
    else begin
      n_checks++; if (obs_q[1].rdctl !== 32'hA2) begin n_fail++; $display("FAIL flush_last_tag got %h want a2", obs_q[1].rdctl); end
      n_checks++; if (cmplt_cyc !== obs_q[1].cyc + 1) begin n_fail++; $display("FAIL flush_cmplt_cycle got %0d want %0d", cmplt_cyc, obs_q[1].cyc + 1); end
    end
    n_checks++; if (mc_rd_rq_stall !== 1'b0 || mc_wr_rq_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stalls_release got %b%b want 00", mc_rd_rq_stall, mc_wr_rq_stall); end
    n_checks++; if (mc_rsp_flush_cmplt !== 1'b0) begin n_fail++; $display("FAIL flush_cmplt_pulse got %b want 0", mc_rsp_flush_cmplt); end
    // flush with nothing pending completes two cycles later
    c0 = cmplt_cnt; t_fl = cyc;
    mc_req_flush = 1'b1;
    @(posedge clock); #1;
    mc_req_flush = 1'b0;
    for (int unsigned i = 0; i < 10 && cmplt_cnt == c0; i++) @(posedge clock);
    #1;
    n_checks++; if (cmplt_cnt == c0 || cmplt_cyc !== t_fl + 2) begin
      n_fail++; $display("FAIL flush_idle_cmplt got cycle %0d want %0d", cmplt_cyc, t_fl + 2); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL flush_err got %b want 0", protocol_err); end
  endtask

  task automatic test_random();
    rsp_rec_t o, e;
    logic [1:0] sz;
    int unsigned r, mism;
    obs_q.delete(); exp_q.delete();
    for (int unsigned w = 0; w < 32; w++) issue_st(48'(w) << 3, 2'd3, {$urandom, $urandom});
    for (int unsigned i = 0; i < 300; i++) begin
      mc_rsp_stall = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r < 5 && !mc_rd_rq_stall) issue_ld(rand_addr(sz), sz, $urandom);
      else if (r < 8 && !mc_wr_rq_stall) issue_st(rand_addr(sz), sz, {$urandom, $urandom});
      else idle_cycle();
    end
    mc_rsp_stall = 1'b0;
    wait_obs(exp_q.size(), 40);
    repeat (3) idle_cycle();
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    mism = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.data !== e.data || o.rdctl !== e.rdctl) begin
        n_fail++; mism++;
        if (mism < 6) $display("FAIL rand_rsp got %h/%h want %h/%h", o.data, o.rdctl, e.data, e.rdctl);
      end
    end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL rand_err got %b want 0", protocol_err); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    issue_ld(48'h40, 2'd3, 32'h31);
    issue_ld(48'h48, 2'd3, 32'h32);
    issue_ld(48'h50, 2'd3, 32'h33);
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({mc_rsp_push, mc_rsp_flush_cmplt, protocol_err, mc_rd_rq_stall, mc_wr_rq_stall} !== 5'b0) begin
      n_fail++; $display("FAIL inflight_ctrl got %b want 00000",
        {mc_rsp_push, mc_rsp_flush_cmplt, protocol_err, mc_rd_rq_stall, mc_wr_rq_stall}); end
    n_checks++; if (mc_rsp_data !== 64'h0 || mc_rsp_rdctl !== 32'h0) begin
      n_fail++; $display("FAIL inflight_data got %h/%h want 0/0", mc_rsp_data, mc_rsp_rdctl); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    obs_q.delete(); exp_q.delete();
    repeat (10) idle_cycle();
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL inflight_stale got %0d pushes want 0", obs_q.size()); end
  endtask

  task automatic test_misaligned();
    rsp_rec_t o, e;
    do_reset();
    issue_ld(48'h41, 2'd1, 32'h99);
    issue_st(48'h42, 2'd2, 64'hFFFF_FFFF);
    repeat (8) idle_cycle();
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL misalign_push got %0d want 0", obs_q.size()); end
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b want 1", protocol_err); end
    exp_q.delete();
    issue_ld(48'h40, 2'd3, 32'h9A);
    wait_obs(1, 20);
    n_checks++;
    if (obs_q.size() < 1) begin n_fail++; $display("FAIL misalign_st_count got %0d want 1", obs_q.size()); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL misalign_st_dropped got %h want %h", o.data, e.data); end
    end
  endtask

  task automatic test_dual_request();
    rsp_rec_t o, e;
    do_reset();
    mc_req_ld = 1'b1; mc_req_st = 1'b1; mc_req_vadr = 48'h40; mc_req_size = 2'd3;
    mc_req_wrd_rdctl = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clock); #1;
    mc_req_ld = 1'b0; mc_req_st = 1'b0;
    repeat (6) idle_cycle();
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL dual_err got %b want 1", protocol_err); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL dual_push got %0d want 0", obs_q.size()); end
    issue_ld(48'h40, 2'd3, 32'h9B);
    wait_obs(1, 20);
    n_checks++;
    if (obs_q.size() < 1) begin n_fail++; $display("FAIL dual_count got %0d want 1", obs_q.size()); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o.data !== e.data) begin n_fail++; $display("FAIL dual_st_dropped got %h want %h", o.data, e.data); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_inflight();
    test_misaligned();
    test_dual_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
